// File: rtl/lane_word_aligner_pkg.sv
// Shared types and defaults for the ADC frontend lane word aligner.
package lane_word_aligner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED,
        ST_FAIL
    } lane_align_state_t;

    localparam int                     DEF_WORD_BITS     = 14;
    localparam logic [DEF_WORD_BITS-1:0] DEF_TRAIN_PATTERN = 14'h2A5;

    // Width of a counter that must hold the value n (never less than 1 bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lane_word_aligner_if.sv
// Serial-in / word-out bus of the lane word aligner.
interface lane_word_aligner_if #(
    parameter int LANES     = 8,
    parameter int WORD_BITS = 14,
    parameter int OFS_W     = $clog2(WORD_BITS)
);
    logic [LANES-1:0]           bit_rise;
    logic [LANES-1:0]           bit_fall;
    logic [LANES-1:0]           bitslip_pulse;
    logic                       train_start;
    logic [LANES*WORD_BITS-1:0] word_data;
    logic                       word_valid;
    logic [LANES*OFS_W-1:0]     lane_offset;
    logic [LANES-1:0]           lane_locked;
    logic                       train_busy;
    logic                       train_fail;

    modport master (
        output bit_rise, bit_fall, bitslip_pulse, train_start,
        input  word_data, word_valid, lane_offset, lane_locked, train_busy, train_fail
    );

    modport slave (
        input  bit_rise, bit_fall, bitslip_pulse, train_start,
        output word_data, word_valid, lane_offset, lane_locked, train_busy, train_fail
    );
endinterface

// File: rtl/lane_word_aligner_lane.sv
// One lane: DDR bit history, offset-selected word framing and the training FSM.
module lane_word_aligner_lane
    import lane_word_aligner_pkg::*;
#(
    parameter int                   WORD_BITS     = DEF_WORD_BITS,
    parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int                   LOCK_COUNT    = 16,
    parameter int                   SLIP_SETTLE   = 2,
    parameter int                   OFS_W         = $clog2(WORD_BITS)
) (
    input  logic                 dco_clk,
    input  logic                 rst,
    input  logic                 bit_rise_i,
    input  logic                 bit_fall_i,
    input  logic                 slip_i,
    input  logic                 train_start_i,
    input  logic                 extract_i,
    input  logic                 word_valid_i,
    output logic [WORD_BITS-1:0] word_o,
    output logic [OFS_W-1:0]     offset_o,
    output logic                 locked_o,
    output logic                 busy_o,
    output logic                 fail_o
);
    localparam int HW = 2 * WORD_BITS;
    localparam int MW = cnt_w(LOCK_COUNT);
    localparam int SW = cnt_w(SLIP_SETTLE);
    localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(WORD_BITS - 1);
    localparam logic [MW-1:0]    LOCK_M1  = MW'(LOCK_COUNT - 1);
    localparam logic [SW-1:0]    SETTLE_N = SW'(SLIP_SETTLE);

    // The oldest bit of a 2*WORD_BITS window is never selectable, so it is not stored.
    logic [HW-4:0]         hist_q;
    logic [HW-2:0]         hist_d;
    logic [WORD_BITS-1:0]  word_q, word_sel;
    lane_align_state_t     state_q, state_d;
    logic [OFS_W-1:0]      ofs_q, ofs_d, ofs_slip;
    logic [OFS_W-1:0]      att_q, att_d;
    logic [MW-1:0]         match_q, match_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic                  locked_q, busy_q, fail_q;

    assign hist_d   = {hist_q, bit_rise_i, bit_fall_i};
    assign word_sel = WORD_BITS'(hist_d >> ofs_q);
    assign ofs_slip = (ofs_q == LAST_OFS) ? '0 : ofs_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        ofs_d    = ofs_q;
        att_d    = att_q;
        match_d  = match_q;
        settle_d = settle_q;
        if (train_start_i) begin
            state_d  = ST_CHECK;
            ofs_d    = '0;
            att_d    = '0;
            match_d  = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOCKED, ST_FAIL: begin
                    if (slip_i) begin
                        ofs_d   = ofs_slip;
                        state_d = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (word_valid_i) begin
                        if (word_q == TRAIN_PATTERN) begin
                            match_d = match_q + 1'b1;
                            if (match_q == LOCK_M1) state_d = ST_LOCKED;
                        end else begin
                            match_d = '0;
                            state_d = (att_q == LAST_OFS) ? ST_FAIL : ST_SLIP;
                        end
                    end
                end
                ST_SLIP: begin
                    ofs_d    = ofs_slip;
                    att_d    = att_q + 1'b1;
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_N)  state_d  = ST_CHECK;
                    else if (word_valid_i)     settle_d = settle_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge dco_clk) begin
        if (rst) begin
            hist_q   <= '0;
            word_q   <= '0;
            state_q  <= ST_IDLE;
            ofs_q    <= '0;
            att_q    <= '0;
            match_q  <= '0;
            settle_q <= '0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            hist_q   <= hist_d[HW-4:0];
            if (extract_i) word_q <= word_sel;
            state_q  <= state_d;
            ofs_q    <= ofs_d;
            att_q    <= att_d;
            match_q  <= match_d;
            settle_q <= settle_d;
            locked_q <= (state_d == ST_LOCKED);
            busy_q   <= (state_d == ST_CHECK) || (state_d == ST_SLIP) || (state_d == ST_SETTLE);
            fail_q   <= (state_d == ST_FAIL);
        end
    end

    assign word_o   = word_q;
    assign offset_o = ofs_q;
    assign locked_o = locked_q;
    assign busy_o   = busy_q;
    assign fail_o   = fail_q;

endmodule

// File: rtl/lane_word_aligner.sv
// DDR-to-word gearbox: shared word phase, per-lane aligners and status aggregation.
module lane_word_aligner
    import lane_word_aligner_pkg::*;
#(
    parameter int                   LANES         = 8,
    parameter int                   WORD_BITS     = DEF_WORD_BITS,
    parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int                   LOCK_COUNT    = 16,
    parameter int                   SLIP_SETTLE   = 2
) (
    input  logic                dco_clk,
    input  logic                rst,
    lane_word_aligner_if.slave  bus
);
    localparam int OFS_W = $clog2(WORD_BITS);
    localparam int HALF  = WORD_BITS / 2;
    localparam int PW    = cnt_w(HALF - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);

    logic [PW-1:0]                     ph_q;
    logic                              wv_q;
    logic                              extract;
    logic [LANES-1:0][WORD_BITS-1:0]   word_w;
    logic [LANES-1:0][OFS_W-1:0]       ofs_w;
    logic [LANES-1:0]                  locked_w, busy_w, fail_w;

    // Two bits arrive per cycle, so a word completes every HALF cycles.
    assign extract = (ph_q == PH_LAST);

    always_ff @(posedge dco_clk) begin
        if (rst) begin
            ph_q <= '0;
            wv_q <= 1'b0;
        end else begin
            ph_q <= extract ? '0 : ph_q + 1'b1;
            wv_q <= extract;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_word_aligner_lane #(
            .WORD_BITS    (WORD_BITS),
            .TRAIN_PATTERN(TRAIN_PATTERN),
            .LOCK_COUNT   (LOCK_COUNT),
            .SLIP_SETTLE  (SLIP_SETTLE),
            .OFS_W        (OFS_W)
        ) u_lane (
            .dco_clk      (dco_clk),
            .rst          (rst),
            .bit_rise_i   (bus.bit_rise[i]),
            .bit_fall_i   (bus.bit_fall[i]),
            .slip_i       (bus.bitslip_pulse[i]),
            .train_start_i(bus.train_start),
            .extract_i    (extract),
            .word_valid_i (wv_q),
            .word_o       (word_w[i]),
            .offset_o     (ofs_w[i]),
            .locked_o     (locked_w[i]),
            .busy_o       (busy_w[i]),
            .fail_o       (fail_w[i])
        );
    end

    assign bus.word_data   = word_w;
    assign bus.word_valid  = wv_q;
    assign bus.lane_offset = ofs_w;
    assign bus.lane_locked = locked_w;
    assign bus.train_busy  = |busy_w;
    assign bus.train_fail  = |fail_w;

endmodule
